ioq_dst_port_demux: RTL and testbench

Receive-side counterpart of the hardwired output-port lookup: consumes the IOQ module header whose destination-port field the lookup stage has written, and steers each packet to the selected output stream(s). Sits between the output-port lookup stage and the per-port output queues. Supports unicast and multicast (one-hot or multi-bit destination mask). Drops packets with an empty mask or a missing IOQ header.

---
 rtl/ioq_dst_port_demux_pkg.sv | 12 +
 rtl/fallthrough_small_fifo.sv | 49 ++++
 rtl/ioq_dst_port_demux.sv | 109 ++++++++++
 tb/tb_ioq_dst_port_demux.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/ioq_dst_port_demux_pkg.sv
// Shared constants for the IOQ destination-port demux: header field position,
// IOQ stage ctrl value and classifier state encodings.
package ioq_dst_port_demux_pkg;

    localparam int unsigned IOQ_DST_PORT_POS = 48;
    localparam logic [7:0]  DEFAULT_IO_QUEUE_STAGE_NUM = 8'hff;

    localparam logic [1:0] ST_START       = 2'd0;
    localparam logic [1:0] ST_MODULE_HDRS = 2'd1;
    localparam logic [1:0] ST_IN_PACKET   = 2'd2;

endpackage

// File: rtl/fallthrough_small_fifo.sv
// Small fall-through FIFO: the head word is visible on dout whenever not empty.
module fallthrough_small_fifo #(
    parameter int unsigned WIDTH          = 72,
    parameter int unsigned MAX_DEPTH_BITS = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             nearly_full,
    output logic             empty
);

    localparam int unsigned DEPTH = 1 << MAX_DEPTH_BITS;
    // One slot of headroom absorbs the write already in flight when nearly_full rises.
    localparam logic [MAX_DEPTH_BITS:0] NEARLY_FULL_LEVEL = (MAX_DEPTH_BITS + 1)'(DEPTH - 1);

    logic [WIDTH-1:0]          mem [DEPTH];
    logic [MAX_DEPTH_BITS-1:0] wr_ptr_q;
    logic [MAX_DEPTH_BITS-1:0] rd_ptr_q;
    logic [MAX_DEPTH_BITS:0]   count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= din;
    end

    assign dout        = mem[rd_ptr_q];
    assign empty       = (count_q == '0);
    assign nearly_full = (count_q >= NEARLY_FULL_LEVEL);

endmodule

// File: rtl/ioq_dst_port_demux.sv
// Steers each packet to the output streams selected by the destination mask in its
// IOQ module header; packets with an empty mask or no IOQ header are dropped.
module ioq_dst_port_demux
    import ioq_dst_port_demux_pkg::*;
#(
    parameter int unsigned DATA_WIDTH        = 64,
    parameter int unsigned CTRL_WIDTH        = DATA_WIDTH / 8,
    parameter logic [CTRL_WIDTH-1:0] IO_QUEUE_STAGE_NUM = CTRL_WIDTH'(DEFAULT_IO_QUEUE_STAGE_NUM),
    parameter int unsigned NUM_OUTPUT_QUEUES = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [DATA_WIDTH-1:0]        in_data,
    input  logic [CTRL_WIDTH-1:0]        in_ctrl,
    input  logic                         in_wr,
    output logic                         in_rdy,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [CTRL_WIDTH-1:0]        out_ctrl,
    output logic [NUM_OUTPUT_QUEUES-1:0] out_wr,
    input  logic [NUM_OUTPUT_QUEUES-1:0] out_rdy,
    output logic                         pkt_dropped,
    output logic                         pkt_forwarded
);

    localparam int unsigned FIFO_WIDTH = 1 + NUM_OUTPUT_QUEUES + CTRL_WIDTH + DATA_WIDTH;

    logic [1:0]                   state_q, state_d;
    logic [NUM_OUTPUT_QUEUES-1:0] mask_q;
    logic [NUM_OUTPUT_QUEUES-1:0] hdr_mask;
    logic [NUM_OUTPUT_QUEUES-1:0] word_mask;
    logic                         sop;

    always_comb begin
        hdr_mask  = (in_ctrl == IO_QUEUE_STAGE_NUM) ?
                    in_data[IOQ_DST_PORT_POS +: NUM_OUTPUT_QUEUES] : '0;
        sop       = (state_q == ST_START);
        word_mask = sop ? hdr_mask : mask_q;
        state_d   = state_q;
        case (state_q)
            ST_START:       state_d = (in_ctrl == '0) ? ST_IN_PACKET : ST_MODULE_HDRS;
            ST_MODULE_HDRS: if (in_ctrl == '0) state_d = ST_IN_PACKET;
            ST_IN_PACKET:   if (in_ctrl != '0) state_d = ST_START;
            default:        state_d = ST_START;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_START;
            mask_q  <= '0;
        end else if (in_wr) begin
            state_q <= state_d;
            if (sop) mask_q <= hdr_mask;
        end
    end

    logic [FIFO_WIDTH-1:0]        fifo_dout;
    logic                         fifo_nearly_full;
    logic                         fifo_empty;
    logic                         head_sop;
    logic [NUM_OUTPUT_QUEUES-1:0] head_mask;
    logic [CTRL_WIDTH-1:0]        head_ctrl;
    logic [DATA_WIDTH-1:0]        head_data;
    logic                         pop;

    fallthrough_small_fifo #(
        .WIDTH          (FIFO_WIDTH),
        .MAX_DEPTH_BITS (2)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .din         ({sop, word_mask, in_ctrl, in_data}),
        .wr_en       (in_wr),
        .rd_en       (pop),
        .dout        (fifo_dout),
        .nearly_full (fifo_nearly_full),
        .empty       (fifo_empty)
    );

    assign {head_sop, head_mask, head_ctrl, head_data} = fifo_dout;
    assign in_rdy = !fifo_nearly_full;

    // Multicast words advance only when every selected port can take them.
    assign pop = !fifo_empty && ((head_mask == '0) || (&(out_rdy | ~head_mask)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_data      <= '0;
            out_ctrl      <= '0;
            out_wr        <= '0;
            pkt_dropped   <= 1'b0;
            pkt_forwarded <= 1'b0;
        end else begin
            out_wr        <= '0;
            pkt_dropped   <= 1'b0;
            pkt_forwarded <= 1'b0;
            if (pop) begin
                out_data <= head_data;
                out_ctrl <= head_ctrl;
                out_wr   <= head_mask;
                if (head_sop) begin
                    pkt_dropped   <= (head_mask == '0);
                    pkt_forwarded <= (head_mask != '0);
                end
            end
        end
    end

endmodule

// File: tb/tb_ioq_dst_port_demux.sv
// Table-driven bench for ioq_dst_port_demux plus a hand-written mid-packet reset sequence.
module tb_ioq_dst_port_demux;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] in_data;
    logic [7:0]  in_ctrl;
    logic        in_wr;
    logic        in_rdy;
    logic [63:0] out_data;
    logic [7:0]  out_ctrl;
    logic [7:0]  out_wr;
    logic [7:0]  out_rdy;
    logic        pkt_dropped;
    logic        pkt_forwarded;

    int checks = 0;
    int errors = 0;

    ioq_dst_port_demux dut (
        .clk           (clk),
        .reset         (reset),
        .in_data       (in_data),
        .in_ctrl       (in_ctrl),
        .in_wr         (in_wr),
        .in_rdy        (in_rdy),
        .out_data      (out_data),
        .out_ctrl      (out_ctrl),
        .out_wr        (out_wr),
        .out_rdy       (out_rdy),
        .pkt_dropped   (pkt_dropped),
        .pkt_forwarded (pkt_forwarded)
    );

    always #5 clk = ~clk;

    // Expectations of each record are sampled at the falling edge before its inputs are driven.
    typedef struct {
        logic        wr;
        logic [63:0] data;
        logic [7:0]  ctrl;
        logic [7:0]  rdy;
        logic [7:0]  e_wr;
        logic [63:0] e_data;
        logic [7:0]  e_ctrl;
        logic        e_drop;
        logic        e_fwd;
        logic        e_rdy;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [63:0] hdr(input logic [7:0] dst);
        return {8'h00, dst, 48'h0000_0003_0040};
    endfunction

    function automatic void v(input logic wr, input logic [63:0] data, input logic [7:0] ctrl,
                              input logic [7:0] rdy, input logic [7:0] e_wr,
                              input logic [63:0] e_data, input logic [7:0] e_ctrl,
                              input logic e_drop, input logic e_fwd, input logic e_rdy);
        vec_t r;
        r.wr = wr; r.data = data; r.ctrl = ctrl; r.rdy = rdy; r.e_wr = e_wr;
        r.e_data = e_data; r.e_ctrl = e_ctrl; r.e_drop = e_drop; r.e_fwd = e_fwd;
        r.e_rdy = e_rdy;
        vecs.push_back(r);
    endfunction

    task automatic chk(input string name, input int idx, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @%0d: got %h expected %h", name, idx, got, exp);
        end
    endtask

    task automatic run(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            @(negedge clk);
            chk("out_wr", i, 64'(out_wr), 64'(vecs[i].e_wr));
            chk("pkt_dropped", i, 64'(pkt_dropped), 64'(vecs[i].e_drop));
            chk("pkt_forwarded", i, 64'(pkt_forwarded), 64'(vecs[i].e_fwd));
            chk("in_rdy", i, 64'(in_rdy), 64'(vecs[i].e_rdy));
            if (vecs[i].e_wr != 8'h00) begin
                chk("out_data", i, out_data, vecs[i].e_data);
                chk("out_ctrl", i, 64'(out_ctrl), 64'(vecs[i].e_ctrl));
            end
            in_wr   = vecs[i].wr;
            in_data = vecs[i].data;
            in_ctrl = vecs[i].ctrl;
            out_rdy = vecs[i].rdy;
        end
    endtask

    int split;

    initial begin
        // Unicast to port 2 with one extra module header.
        v(1, hdr(8'h04), 8'hff, 8'hff, 8'h00, 0, 0, 0, 0, 1);
        v(1, 64'hA1, 8'h10, 8'hff, 8'h00, 0, 0, 0, 0, 1);
        v(1, 64'hA2, 8'h00, 8'hff, 8'h04, hdr(8'h04), 8'hff, 0, 1, 1);
        v(1, 64'hA3, 8'h00, 8'hff, 8'h04, 64'hA1, 8'h10, 0, 0, 1);
        v(1, 64'hA4, 8'h08, 8'hff, 8'h04, 64'hA2, 8'h00, 0, 0, 1);
        v(0, 0, 0, 8'hff, 8'h04, 64'hA3, 8'h00, 0, 0, 1);
        v(0, 0, 0, 8'hff, 8'h04, 64'hA4, 8'h08, 0, 0, 1);
        v(0, 0, 0, 8'hff, 8'h00, 0, 0, 0, 0, 1);
        // Multicast to ports 0 and 2 while port 2 is stalled; FIFO fills.
        v(1, hdr(8'h05), 8'hff, 8'h01, 8'h00, 0, 0, 0, 0, 1);
        v(1, 64'hB1, 8'h00, 8'h01, 8'h00, 0, 0, 0, 0, 1);
        v(1, 64'hB2, 8'h00, 8'h01, 8'h00, 0, 0, 0, 0, 1);
        v(1, 64'hB3, 8'h04, 8'h01, 8'h00, 0, 0, 0, 0, 0);
        v(0, 0, 0, 8'hff, 8'h00, 0, 0, 0, 0, 0);
        v(0, 0, 0, 8'hff, 8'h05, hdr(8'h05), 8'hff, 0, 1, 0);
        v(0, 0, 0, 8'hff, 8'h05, 64'hB1, 8'h00, 0, 0, 1);
        v(0, 0, 0, 8'hff, 8'h05, 64'hB2, 8'h00, 0, 0, 1);
        v(0, 0, 0, 8'hff, 8'h05, 64'hB3, 8'h04, 0, 0, 1);
        v(0, 0, 0, 8'hff, 8'h00, 0, 0, 0, 0, 1);
        // Empty-mask packet dropped, then dst 0x02 packet back to back.
        v(1, hdr(8'h00), 8'hff, 8'hff, 8'h00, 0, 0, 0, 0, 1);
        v(1, 64'hC1, 8'h00, 8'hff, 8'h00, 0, 0, 0, 0, 1);
        v(1, 64'hC2, 8'h00, 8'hff, 8'h00, 0, 0, 1, 0, 1);
        v(1, 64'hC3, 8'h01, 8'hff, 8'h00, 0, 0, 0, 0, 1);
        v(1, hdr(8'h02), 8'hff, 8'hff, 8'h00, 0, 0, 0, 0, 1);
        v(1, 64'hD1, 8'h00, 8'hff, 8'h00, 0, 0, 0, 0, 1);
        v(1, 64'hD2, 8'h02, 8'hff, 8'h02, hdr(8'h02), 8'hff, 0, 1, 1);
        v(0, 0, 0, 8'hff, 8'h02, 64'hD1, 8'h00, 0, 0, 1);
        v(0, 0, 0, 8'hff, 8'h02, 64'hD2, 8'h02, 0, 0, 1);
        v(0, 0, 0, 8'hff, 8'h00, 0, 0, 0, 0, 1);
        // No IOQ header: first word ctrl 0x40, dst-looking bits must be ignored.
        v(1, 64'h00FF_0000_0000_00E0, 8'h40, 8'hff, 8'h00, 0, 0, 0, 0, 1);
        v(1, 64'hE1, 8'h00, 8'hff, 8'h00, 0, 0, 0, 0, 1);
        v(1, 64'hE2, 8'h80, 8'hff, 8'h00, 0, 0, 1, 0, 1);
        v(0, 0, 0, 8'hff, 8'h00, 0, 0, 0, 0, 1);
        v(0, 0, 0, 8'hff, 8'h00, 0, 0, 0, 0, 1);
        // Back-to-back packets, mask switches on the second packet's first word.
        v(1, hdr(8'h01), 8'hff, 8'hff, 8'h00, 0, 0, 0, 0, 1);
        v(1, 64'hF1, 8'h00, 8'hff, 8'h00, 0, 0, 0, 0, 1);
        v(1, 64'hF2, 8'h01, 8'hff, 8'h01, hdr(8'h01), 8'hff, 0, 1, 1);
        v(1, hdr(8'h80), 8'hff, 8'hff, 8'h01, 64'hF1, 8'h00, 0, 0, 1);
        v(1, 64'h61, 8'h00, 8'hff, 8'h01, 64'hF2, 8'h01, 0, 0, 1);
        v(1, 64'h62, 8'h03, 8'hff, 8'h80, hdr(8'h80), 8'hff, 0, 1, 1);
        v(0, 0, 0, 8'hff, 8'h80, 64'h61, 8'h00, 0, 0, 1);
        v(0, 0, 0, 8'hff, 8'h80, 64'h62, 8'h03, 0, 0, 1);
        v(0, 0, 0, 8'hff, 8'h00, 0, 0, 0, 0, 1);
        split = vecs.size();
        // Full packet after a mid-packet reset.
        v(1, hdr(8'h10), 8'hff, 8'hff, 8'h00, 0, 0, 0, 0, 1);
        v(1, 64'h71, 8'h00, 8'hff, 8'h00, 0, 0, 0, 0, 1);
        v(1, 64'h72, 8'h20, 8'hff, 8'h10, hdr(8'h10), 8'hff, 0, 1, 1);
        v(0, 0, 0, 8'hff, 8'h10, 64'h71, 8'h00, 0, 0, 1);
        v(0, 0, 0, 8'hff, 8'h10, 64'h72, 8'h20, 0, 0, 1);
        v(0, 0, 0, 8'hff, 8'h00, 0, 0, 0, 0, 1);

        reset   = 1'b0;
        in_wr   = 1'b0;
        in_data = '0;
        in_ctrl = '0;
        out_rdy = 8'hff;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_out_wr", 0, 64'(out_wr), 64'h0);
        chk("rst_out_data", 0, out_data, 64'h0);
        chk("rst_out_ctrl", 0, 64'(out_ctrl), 64'h0);
        chk("rst_pkt_dropped", 0, 64'(pkt_dropped), 64'h0);
        chk("rst_pkt_forwarded", 0, 64'(pkt_forwarded), 64'h0);
        chk("rst_in_rdy", 0, 64'(in_rdy), 64'h1);

        run(0, split);

        // Mid-packet reset: header of a dst 0x08 packet is on the output when reset hits.
        @(negedge clk);
        in_wr = 1'b1; in_data = hdr(8'h08); in_ctrl = 8'hff;
        @(negedge clk);
        in_data = 64'h51; in_ctrl = 8'h00;
        @(negedge clk);
        chk("pre_rst_out_wr", 0, 64'(out_wr), 64'h08);
        chk("pre_rst_out_data", 0, out_data, hdr(8'h08));
        in_wr = 1'b0; in_data = '0; in_ctrl = '0;
        #1 reset = 1'b0;
        #1;
        chk("mid_rst_out_wr", 0, 64'(out_wr), 64'h0);
        chk("mid_rst_out_data", 0, out_data, 64'h0);
        chk("mid_rst_pkt_forwarded", 0, 64'(pkt_forwarded), 64'h0);
        chk("mid_rst_in_rdy", 0, 64'(in_rdy), 64'h1);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        run(split, vecs.size());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
